// File: rtl/calc_op_scheduler_if.sv
// calc_op_scheduler_if: two request channels, calculator drive/accumulator and response channel
//   master: request/response side plus the calculator accumulator source
//   slave : the scheduler
interface calc_op_scheduler_if #(
    parameter int BITS = 32
);
    logic            req0_valid;
    logic [4:0]      req0_op;
    logic [15:0]     req0_operand;
    logic            req0_ready;
    logic            req1_valid;
    logic [4:0]      req1_op;
    logic [15:0]     req1_operand;
    logic            req1_ready;
    logic            calc_start;
    logic [4:0]      calc_buttons;
    logic [15:0]     calc_switch;
    logic [BITS-1:0] calc_accum;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [BITS-1:0] rsp_data;
    logic            busy;
    modport master (
        output req0_valid, req0_op, req0_operand, req1_valid, req1_op, req1_operand,
        output calc_accum, rsp_ready,
        input  req0_ready, req1_ready, calc_start, calc_buttons, calc_switch,
        input  rsp_valid, rsp_id, rsp_data, busy
    );
    modport slave (
        input  req0_valid, req0_op, req0_operand, req1_valid, req1_op, req1_operand,
        input  calc_accum, rsp_ready,
        output req0_ready, req1_ready, calc_start, calc_buttons, calc_switch,
        output rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/calc_op_scheduler.sv
// calc_op_scheduler: round-robin feed of two requesters' commands into one calculator, returning the accumulator
//   clk, reset : clock, asynchronous active-high reset (shared with the calculator)
//   bus        : slave view of request channels, calculator start/buttons/switch/accum, response channel, busy
module calc_op_scheduler #(
    parameter int BITS     = 32,
    parameter int CALC_LAT = 3
) (
    input logic                clk,
    input logic                reset,
    calc_op_scheduler_if.slave bus
);
    localparam int CW = $clog2(CALC_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [4:0]      op_q, op_d;
    logic [15:0]     operand_q, operand_d;
    logic            id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            gnt1, take;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    // Ready is masked during reset so no handshake can be lost while the FSM is held.
    assign take = (state_q == IDLE) & ~reset & (bus.req0_valid | bus.req1_valid);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_q        <= '0;
            operand_q   <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        operand_d   = operand_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (take) begin
                state_d   = ISSUE;
                op_d      = gnt1 ? bus.req1_op : bus.req0_op;
                operand_d = gnt1 ? bus.req1_operand : bus.req0_operand;
                id_d      = gnt1;
                last_d    = gnt1;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(CALC_LAT - 1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d     = RESP;
                rsp_data_d  = bus.calc_accum;
                rsp_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end
    always_comb begin
        bus.req0_ready   = take & ~gnt1;
        bus.req1_ready   = take & gnt1;
        bus.calc_start   = state_q == ISSUE;
        // Operand stays on the switches through WAIT because the calculator reads it there.
        bus.calc_buttons = (state_q == ISSUE || state_q == WAIT) ? op_q : '0;
        bus.calc_switch  = (state_q == ISSUE || state_q == WAIT) ? operand_q : '0;
        bus.rsp_valid    = rsp_valid_q;
        bus.rsp_id       = id_q;
        bus.rsp_data     = rsp_data_q;
        bus.busy         = state_q != IDLE;
    end
endmodule

// File: tb/tb_calc_op_scheduler.sv
// tb_calc_op_scheduler: directed table plus corner-case sequences against a behavioural calculator
module tb_calc_op_scheduler;
    localparam int CALC_LAT = 3;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;
    localparam logic [4:0] OP_UP = 5'b00001, OP_DOWN = 5'b00010, OP_LEFT = 5'b00100;
    localparam logic [4:0] OP_RIGHT = 5'b01000, OP_CENTER = 5'b10000;
    typedef struct {
        logic        id;
        logic [4:0]  op;
        logic [15:0] operand;
        logic [31:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [CALC_LAT-2:0] sh;
    calc_op_scheduler_if #(.BITS(32)) bus ();
    calc_op_scheduler #(.BITS(32), .CALC_LAT(CALC_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] calc(input logic [31:0] a, input logic [4:0] b, input logic [15:0] s);
        logic [31:0] x;
        x = {{16{s[15]}}, s};
        return b[UP] ? a * x : b[DOWN] ? 32'd0 : b[LEFT] ? a + x : b[RIGHT] ? a - x : a;
    endfunction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
            bus.calc_accum <= '0;
        end else begin
            sh <= {sh[CALC_LAT-3:0], bus.calc_start};
            if (sh[CALC_LAT-2]) bus.calc_accum <= calc(bus.calc_accum, bus.calc_buttons, bus.calc_switch);
        end
    end
    always @(posedge clk) if (bus.calc_start) start_cnt <= start_cnt + 1;
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick;
            n++;
        end
    endtask
    task automatic do_cmd(input logic id, input logic [4:0] op, input logic [15:0] opd, input logic [31:0] exp);
        int n;
        int s0;
        if (id) begin
            bus.req1_op = op; bus.req1_operand = opd; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_operand = opd; bus.req0_valid = 1'b1;
        end
        #1;
        chk("ready_own", 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
        chk("ready_other", 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
        s0 = start_cnt;
        tick;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("start", 32'(bus.calc_start), 32'd1);
        chk("ready_drop", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        wait_rsp(n);
        chk("rsp_latency", 32'(n), 32'(CALC_LAT + 1));
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_data", bus.rsp_data, exp);
        chk("start_once", 32'(start_cnt - s0), 32'd1);
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("idle", 32'(bus.busy), 32'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t vt[9];
        logic [31:0] cexp[4];
        int n;
        int seen;
        vt[0] = '{1'b0, OP_LEFT,   16'd5,    32'd5};
        vt[1] = '{1'b1, OP_UP,     16'hFFFD, 32'hFFFFFFF1};
        vt[2] = '{1'b0, OP_RIGHT,  16'd1,    32'hFFFFFFF0};
        vt[3] = '{1'b1, OP_DOWN,   16'd0,    32'd0};
        vt[4] = '{1'b0, OP_CENTER, 16'd7,    32'd0};
        vt[5] = '{1'b1, OP_LEFT,   16'd100,  32'd100};
        vt[6] = '{1'b0, 5'b00101,  16'd2,    32'd200};
        vt[7] = '{1'b1, 5'b00000,  16'd9,    32'd200};
        vt[8] = '{1'b0, OP_RIGHT,  16'hFFCE, 32'd250};
        cexp = '{32'd1, 32'd11, 32'd12, 32'd22};
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_operand = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_operand = '0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_start", 32'(bus.calc_start), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        reset = 1'b0;
        tick;
        for (int i = 0; i < 9; i++) do_cmd(vt[i].id, vt[i].op, vt[i].operand, vt[i].exp);
        bus.req0_op = OP_LEFT; bus.req0_operand = 16'd4; bus.req0_valid = 1'b1;
        #1;
        tick;
        bus.req0_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_buttons", 32'(bus.calc_buttons), 32'd0);
        chk("mid_rst_switch", 32'(bus.calc_switch), 32'd0);
        chk("mid_rst_rsp_data", bus.rsp_data, 32'd0);
        tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.rsp_valid || bus.busy) seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
        do_cmd(1'b0, OP_LEFT, 16'd2, 32'd2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        bus.req0_op = OP_LEFT; bus.req0_operand = 16'd1; bus.req0_valid = 1'b1;
        bus.req1_op = OP_LEFT; bus.req1_operand = 16'd10; bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(bus.req0_ready | bus.req1_ready) && n < 20) begin
                tick;
                n++;
            end
            chk("c_grant_wait", 32'(n < 20), 32'd1);
            chk("c_one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            chk("c_order", 32'(bus.req1_ready), 32'(k[0]));
            tick;
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            wait_rsp(n);
            chk("c_rsp_latency", 32'(n), 32'(CALC_LAT + 1));
            chk("c_rsp_id", 32'(bus.rsp_id), 32'(k[0]));
            chk("c_rsp_data", bus.rsp_data, cexp[k]);
            bus.rsp_ready = 1'b1;
            tick;
            bus.rsp_ready = 1'b0;
        end
        chk("c_idle", 32'(bus.busy), 32'd0);
        bus.req0_op = OP_LEFT; bus.req0_operand = 16'd3; bus.req0_valid = 1'b1;
        bus.req1_op = OP_LEFT; bus.req1_operand = 16'd5; bus.req1_valid = 1'b1;
        #1;
        chk("bp_grant0", 32'(bus.req0_ready), 32'd1);
        chk("bp_no_grant1", 32'(bus.req1_ready), 32'd0);
        tick;
        bus.req0_valid = 1'b0;
        wait_rsp(n);
        chk("bp_rsp_latency", 32'(n), 32'(CALC_LAT + 1));
        chk("bp_rsp_data", bus.rsp_data, 32'd25);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold_data", bus.rsp_data, 32'd25);
            chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            chk("bp_no_ready", 32'(bus.req1_ready | bus.req0_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk("bp_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(bus.req1_ready), 32'd1);
        tick;
        bus.req1_valid = 1'b0;
        chk("bp_next_start", 32'(bus.calc_start), 32'd1);
        wait_rsp(n);
        chk("bp_next_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_next_data", bus.rsp_data, 32'd30);
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk("bp_final_idle", 32'(bus.busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
